// File: rtl/otfc_ctrl.sv
// otfc_ctrl: on-the-fly conversion of an MSB-first signed-digit stream to a two's-complement word
package rbr_pkg;
   typedef struct packed {
      logic plus;
      logic minus;
   } signed_digit;
endpackage

module otfc_ctrl #(
   parameter int WIDTH = 16,
   parameter int SKIP  = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   input  logic                     d_valid,
   output logic                     d_ready,
   input  rbr_pkg::signed_digit     d,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res,
   output logic [$clog2(WIDTH)-1:0] digit_idx
);
   localparam int JW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
   localparam logic [JW-1:0] LAST = JW'(WIDTH - 2);
   localparam logic [3:0] SKIP_LAST = 4'(SKIP - 1);

   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CONV, S_DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] q, q_nx, qm, qm_nx, b;
   logic [JW-1:0]    j, j_nx;
   logic [3:0]       sc, sc_nx;
   logic             take, init, pos, neg;

   assign busy      = state != S_IDLE;
   assign d_ready   = state == S_SKIP || state == S_CONV;
   assign res_valid = state == S_DONE;
   assign res       = q;
   assign digit_idx = j;
   assign take      = d_valid & d_ready;
   assign init      = start & (state == S_IDLE || (state == S_DONE && res_ready));
   assign pos       = d.plus & ~d.minus;
   assign neg       = d.minus & ~d.plus;
   // digit j lands on bit WIDTH-2-j, just below the sign bit
   assign b         = WIDTH'(1) << (LAST - j);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= S_IDLE;
         q     <= '0;
         qm    <= MSB;
         j     <= '0;
         sc    <= '0;
      end else begin
         state <= state_nx;
         q     <= q_nx;
         qm    <= qm_nx;
         j     <= j_nx;
         sc    <= sc_nx;
      end

   always_comb begin
      state_nx = state;
      q_nx     = q;
      qm_nx    = qm;
      j_nx     = j;
      sc_nx    = sc;
      if (abort || init) begin
         state_nx = abort ? S_IDLE : (SKIP > 0) ? S_SKIP : S_CONV;
         q_nx     = '0;
         qm_nx    = MSB;
         j_nx     = '0;
         sc_nx    = '0;
      end else if (state == S_SKIP && take) begin
         sc_nx    = sc + 4'd1;
         state_nx = (sc == SKIP_LAST) ? S_CONV : S_SKIP;
      end else if (state == S_CONV && take) begin
         q_nx     = pos ? (q | b) : neg ? (qm | b) : q;
         qm_nx    = pos ? q : neg ? qm : (qm | b);
         j_nx     = j + JW'(1);
         state_nx = (j == LAST) ? S_DONE : S_CONV;
      end else if (state == S_DONE && res_ready) begin
         state_nx = S_IDLE;
      end
   end
endmodule

// File: doc/otfc_ctrl.md
# otfc_ctrl

Sequencing controller for on-the-fly conversion of an MSB-first radix-2 signed-digit stream into a two's-complement word. It sits at the output of the online arithmetic units. It owns the Q/QM register pair and the digit index, discards the operator's online-delay digits, and applies one conversion step per accepted digit. It then holds the finished word behind a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, result width. Conversion consumes exactly WIDTH-1 digits (one sign bit, WIDTH-1 fraction bits).
- SKIP, 0, number of leading digit beats discarded (online delay δ) before conversion starts. Range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new conversion. Sampled in IDLE, and in DONE together with res_ready.
- abort  in  1  synchronous abort to IDLE; highest priority.
- busy  out  1  state != IDLE.
- d_valid  in  1  digit present.
- d_ready  out  1  controller accepts a digit this cycle.
- d  in  signed_digit (rbr_pkg)  digit. plus&!minus = +1, minus&!plus = -1, plus==minus = 0.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes the result.
- res  out  WIDTH  converted two's-complement fraction (Q register).
- digit_idx  out  $clog2(WIDTH)  index j of the next digit to convert.

## Operation
- Value converted: X = Σ d_j·2^-(j+1) for j = 0..WIDTH-2. Digit j maps to bit position p = WIDTH-2-j. Bit WIDTH-1 is the sign.
- Init on start: Q = 0, QM = 1<<(WIDTH-1) (i.e. -1), j = 0, skip count = 0.
- Per accepted digit in CONV, with b = 1<<p:
  - +1: Q' = Q|b, QM' = Q.
  - 0: Q' = Q, QM' = QM|b.
  - -1: Q' = QM|b, QM' = QM.
- No adders. Only OR and select; Q/QM are WIDTH bits and never overflow.
- FSM states:
  - IDLE: d_ready=0. start → SKIP if SKIP>0, else CONV. Init applied.
  - SKIP: d_ready=1. Accepted beats are discarded and the skip count increments. The SKIP-th accepted beat → CONV.
  - CONV: d_ready=1. Each accepted beat updates Q/QM and increments j. The beat with j = WIDTH-2 → DONE.
  - DONE: d_ready=0, res_valid=1, res = Q held stable. res_ready → IDLE. res_ready&start → re-init and go to SKIP/CONV, giving back-to-back conversions.
- start outside IDLE/DONE-handshake is ignored.
- abort in any state → IDLE next cycle. It clears Q, QM, counters and res_valid, and overrides start, digit acceptance and res_ready in the same cycle.
- A digit with d_valid=0 causes no state change (stalls are unbounded).
- Reset values: state IDLE, Q = 0, QM = 1<<(WIDTH-1), j = 0, skip count = 0, busy = 0, d_ready = 0, res_valid = 0, res = 0, digit_idx = 0.

## Timing
- d_ready, res_valid, busy and res are decoded from registered state only. None of them is combinational on d_valid or res_ready.
- start sampled at edge 0 → d_ready=1 from cycle 1.
- Digit transfer occurs on an edge with d_valid&d_ready.
- The last digit transfers at edge k → res_valid=1 from cycle k+1.
- Minimum start-to-res_valid latency with no stalls: 1 + SKIP + (WIDTH-1) cycles.
- Result handshake completes on an edge with res_valid&res_ready. res_valid drops the next cycle unless a back-to-back start re-enters via SKIP/CONV, in which case it still drops.
- digit_idx updates on the same edge as Q/QM.

## Test plan
- WIDTH=8, SKIP=0: digits +1,-1,0,0,0,0,0 → res=8'h20, res_valid exactly 8 cycles after start, busy low after res_ready.
- WIDTH=8: all seven digits -1 → res=8'h81; all +1 → 8'h7F; all 0 (mix of plus=minus=0 and plus=minus=1) → 8'h00.
- WIDTH=8, SKIP=3: three junk beats (+1,+1,-1) then +1,0,0,0,0,0,0 → res=8'h40; junk has no effect; digit_idx stays 0 during SKIP.
- Random d_valid gaps and res_ready held low 5 cycles → same results as the unstalled runs; res stable and d_ready=0 throughout DONE.
- abort asserted after the 3rd converted digit, with d_valid high the same cycle → IDLE next cycle, Q=0, QM=8'h80, that digit not consumed. A new start then converts correctly.
- start together with res_ready in DONE → next conversion begins, d_ready=1 the following cycle. rst_n pulsed mid-CONV → all outputs at reset values immediately, without waiting for a clock edge.
